// File: rtl/pkt_rx_parser.sv
// pkt_rx_parser: word-stream packet receiver that parses routing fields and filters echoes.
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   in_valid/in_ready, in_data word handshake and received word
//   in_sop                     marks in_data as a packet header
//   myNodeID                   own node ID; packets sourced by it are dropped
//   newpkt                     one-cycle pulse when the field outputs carry a new packet
//   fPacketType .. fTimeslot   parsed header type and words 1..5 of the last delivered packet
//   channel_clear              medium has been idle for CLEAR_CYCLES cycles
//   rx_error                   one-cycle pulse on abort (early sop or inter-word timeout)
//   pkt_count, drop_count      saturating delivered / dropped packet counts
module pkt_rx_parser #(
    parameter int WORD_WIDTH   = 16,
    parameter int TIMEOUT      = 64,
    parameter int CLEAR_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_sop,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    output logic                  newpkt,
    output logic [2:0]            fPacketType,
    output logic [WORD_WIDTH-1:0] sourceID,
    output logic [WORD_WIDTH-1:0] destinationID,
    output logic [WORD_WIDTH-1:0] fHopsFromCH,
    output logic [WORD_WIDTH-1:0] fChosenCH,
    output logic [WORD_WIDTH-1:0] fTimeslot,
    output logic                  channel_clear,
    output logic                  rx_error,
    output logic [7:0]            pkt_count,
    output logic [7:0]            drop_count
);
    localparam int GW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(CLEAR_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FIELDS, SKIP, EMIT} state_t;
    state_t state, state_nx;

    logic                  run;
    logic [2:0]            word_cnt, typ;
    logic [4:0]            len, pay_cnt;
    logic [GW-1:0]         gap;
    logic [IW-1:0]         idle_cnt, idle_nx;
    logic [WORD_WIDTH-1:0] sh_src, sh_dst, sh_hops, sh_ch, sh_ts;
    logic                  acc, busy, hdr, abort, tmo, drop;

    // run holds in_ready low during reset and releases it on the first edge afterwards
    assign in_ready = run && state != EMIT;
    assign acc      = in_valid && in_ready;
    assign busy     = state == FIELDS || state == SKIP;
    assign drop     = sh_src == myNodeID || typ == 3'b111;
    assign idle_nx  = (state == IDLE && !in_valid)
                    ? ((idle_cnt == IW'(CLEAR_CYCLES)) ? idle_cnt : idle_cnt + 1'b1)
                    : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        hdr      = 1'b0;
        abort    = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: if (acc && in_sop) begin
                state_nx = FIELDS;
                hdr      = 1'b1;
            end
            FIELDS, SKIP: begin
                // a fresh header always wins: abort and restart parsing from it
                if (acc && in_sop) begin
                    state_nx = FIELDS;
                    hdr      = 1'b1;
                    abort    = 1'b1;
                end else if (acc) begin
                    if (state == FIELDS && word_cnt == 3'd5)
                        state_nx = (len == 5'd0) ? EMIT : SKIP;
                    else if (state == SKIP && pay_cnt + 5'd1 == len)
                        state_nx = EMIT;
                end else if (gap == GW'(TIMEOUT - 1)) begin
                    // this idle cycle brings the gap to TIMEOUT
                    state_nx = IDLE;
                    tmo      = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            run           <= 1'b0;
            word_cnt      <= '0;
            typ           <= '0;
            len           <= '0;
            pay_cnt       <= '0;
            gap           <= '0;
            idle_cnt      <= '0;
            sh_src        <= '0;
            sh_dst        <= '0;
            sh_hops       <= '0;
            sh_ch         <= '0;
            sh_ts         <= '0;
            newpkt        <= 1'b0;
            fPacketType   <= '0;
            sourceID      <= '0;
            destinationID <= '0;
            fHopsFromCH   <= '0;
            fChosenCH     <= '0;
            fTimeslot     <= '0;
            channel_clear <= 1'b0;
            rx_error      <= 1'b0;
            pkt_count     <= '0;
            drop_count    <= '0;
        end else begin
            run           <= 1'b1;
            newpkt        <= 1'b0;
            rx_error      <= abort || tmo;
            idle_cnt      <= idle_nx;
            channel_clear <= idle_nx == IW'(CLEAR_CYCLES);
            gap           <= (busy && !acc) ? gap + 1'b1 : '0;
            if (hdr) begin
                typ      <= in_data[WORD_WIDTH-1 -: 3];
                len      <= in_data[WORD_WIDTH-4 -: 5];
                word_cnt <= 3'd1;
                pay_cnt  <= '0;
            end else if (acc && state == FIELDS) begin
                word_cnt <= word_cnt + 3'd1;
                if (word_cnt == 3'd1) sh_src  <= in_data;
                if (word_cnt == 3'd2) sh_dst  <= in_data;
                if (word_cnt == 3'd3) sh_hops <= in_data;
                if (word_cnt == 3'd4) sh_ch   <= in_data;
                if (word_cnt == 3'd5) sh_ts   <= in_data;
            end else if (acc && state == SKIP) begin
                pay_cnt <= pay_cnt + 5'd1;
            end
            if (state == EMIT) begin
                if (drop) begin
                    drop_count <= drop_count + {7'd0, drop_count != 8'hff};
                end else begin
                    newpkt        <= 1'b1;
                    fPacketType   <= typ;
                    sourceID      <= sh_src;
                    destinationID <= sh_dst;
                    fHopsFromCH   <= sh_hops;
                    fChosenCH     <= sh_ch;
                    fTimeslot     <= sh_ts;
                    pkt_count     <= pkt_count + {7'd0, pkt_count != 8'hff};
                end
            end
        end
    end
endmodule

// File: tb/tb_pkt_rx_parser.sv
// tb_pkt_rx_parser: randomized self-checking bench for pkt_rx_parser against a packet-level model.
module tb_pkt_rx_parser;
    logic        clk = 1'b0, nrst = 1'b0, in_valid = 1'b0, in_sop = 1'b0;
    logic [15:0] in_data = '0, my_node = '0;
    logic        in_ready, newpkt, channel_clear, rx_error;
    logic [2:0]  fPacketType;
    logic [15:0] sourceID, destinationID, fHopsFromCH, fChosenCH, fTimeslot;
    logic [7:0]  pkt_count, drop_count;

    pkt_rx_parser dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sop(in_sop), .myNodeID(my_node), .newpkt(newpkt),
        .fPacketType(fPacketType), .sourceID(sourceID), .destinationID(destinationID),
        .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH), .fTimeslot(fTimeslot),
        .channel_clear(channel_clear), .rx_error(rx_error),
        .pkt_count(pkt_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  typ;
        logic [4:0]  len;
        logic [15:0] src, dst, hops, ch, ts;
    } pkt_t;
    typedef struct packed {
        logic [2:0]  typ;
        logic [15:0] src, dst, hops, ch, ts;
    } rec_t;

    int   checks = 0, errors = 0, cyc = 0, err_pulses = 0;
    int   exp_pkt = 0, exp_drop = 0;
    int   last_acc = 0, last_stall = 0, first_acc = 0, first_stall = 0;
    rec_t got_q[$], exp_q[$];
    int   np_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (newpkt) begin
            got_q.push_back({fPacketType, sourceID, destinationID, fHopsFromCH, fChosenCH, fTimeslot});
            np_cyc.push_back(cyc);
        end
        if (rx_error) err_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic pkt_t mk(input logic [2:0] t, input logic [4:0] l, input logic [15:0] s,
                                input logic [15:0] d, input logic [15:0] h, input logic [15:0] c,
                                input logic [15:0] ts);
        mk = '{typ: t, len: l, src: s, dst: d, hops: h, ch: c, ts: ts};
    endfunction

    function automatic pkt_t rnd_pkt(input bit deliver);
        rnd_pkt = mk(deliver ? 3'($urandom_range(6, 0)) : 3'($urandom_range(7, 0)),
                     5'($urandom_range(6, 0)),
                     deliver ? 16'($urandom_range(16'hffff, 3)) : 16'($urandom_range(3, 1)),
                     16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endfunction

    // Packet-level reference: echoes and type 7 are dropped, everything else delivered.
    task automatic model_pkt(input pkt_t p);
        if (p.src == my_node || p.typ == 3'b111) begin
            exp_drop = exp_drop < 255 ? exp_drop + 1 : 255;
        end else begin
            exp_q.push_back({p.typ, p.src, p.dst, p.hops, p.ch, p.ts});
            exp_pkt = exp_pkt < 255 ? exp_pkt + 1 : 255;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic s);
        int n = 0;
        bit got = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        while (!got && n < 20) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) begin
            errors++;
            $display("FAIL handshake: in_ready stayed %b for %0d cycles, required 1", in_ready, n);
        end
        last_acc   = cyc;
        last_stall = n - 1;
        in_valid   = 1'b0;
        in_sop     = 1'b0;
    endtask

    task automatic send_pkt(input pkt_t p, input int gap_max);
        logic [15:0] w[6];
        w[0] = {p.typ, p.len, 8'h00};
        w[1] = p.src;
        w[2] = p.dst;
        w[3] = p.hops;
        w[4] = p.ch;
        w[5] = p.ts;
        for (int i = 0; i < 6 + int'(p.len); i++) begin
            if (i > 0 && gap_max > 0) idle($urandom_range(gap_max, 0));
            send_word(i < 6 ? w[i] : 16'($urandom), i == 0);
            if (i == 0) begin
                first_acc   = last_acc;
                first_stall = last_stall;
            end
        end
        model_pkt(p);
    endtask

    task automatic clear_q;
        got_q.delete();
        exp_q.delete();
        np_cyc.delete();
    endtask

    task automatic test_reset;
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", in_ready); end
        checks++; if (newpkt !== 1'b0 || rx_error !== 1'b0 || channel_clear !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b%b exp 000", newpkt, rx_error, channel_clear); end
        checks++; if (pkt_count !== 8'd0 || drop_count !== 8'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", pkt_count, drop_count); end
        checks++; if ({fPacketType, sourceID, destinationID, fHopsFromCH, fChosenCH, fTimeslot} !== '0) begin errors++; $display("FAIL reset_fields: got %h exp 0", sourceID); end
        @(posedge clk);
        #1 nrst = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %b exp 0", in_ready); end
        idle(1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_first_edge_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_basic;
        pkt_t p = mk(3'd3, 5'd0, 16'h0007, 16'h0002, 16'h0001, 16'h0005, 16'h0003);
        my_node = 16'h0002;
        clear_q();
        send_pkt(p, 0);
        checks++; if (sourceID !== 16'h0) begin errors++; $display("FAIL basic_shadow: sourceID %h exp 0 before delivery", sourceID); end
        idle(3);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d newpkt pulses exp 1", got_q.size()); end
        if (np_cyc.size() > 0) begin
            checks++; if (np_cyc[0] !== last_acc + 1) begin errors++; $display("FAIL basic_latency: newpkt at %0d exp %0d", np_cyc[0], last_acc + 1); end
        end
        checks++; if (fPacketType !== 3'd3 || sourceID !== 16'd7 || fChosenCH !== 16'd5) begin errors++; $display("FAIL basic_fields: got %0d/%h/%h exp 3/0007/0005", fPacketType, sourceID, fChosenCH); end
        checks++; if (destinationID !== 16'd2 || fHopsFromCH !== 16'd1 || fTimeslot !== 16'd3) begin errors++; $display("FAIL basic_fields2: got %h/%h/%h exp 0002/0001/0003", destinationID, fHopsFromCH, fTimeslot); end
        checks++; if (pkt_count !== 8'(exp_pkt)) begin errors++; $display("FAIL basic_pkt_count: got %0d exp %0d", pkt_count, exp_pkt); end
    endtask

    task automatic test_drop;
        clear_q();
        send_pkt(mk(3'd3, 5'd0, 16'h0002, 16'h0009, 16'h0008, 16'h0006, 16'h0004), 0);
        send_pkt(mk(3'd7, 5'd1, 16'h0009, 16'h0009, 16'h0008, 16'h0006, 16'h0004), 0);
        idle(3);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL drop_newpkt: got %0d pulses exp 0", got_q.size()); end
        checks++; if (drop_count !== 8'(exp_drop)) begin errors++; $display("FAIL drop_count: got %0d exp %0d", drop_count, exp_drop); end
        checks++; if (sourceID !== 16'd7 || fChosenCH !== 16'd5 || fPacketType !== 3'd3) begin errors++; $display("FAIL drop_hold: got %h/%h/%0d exp 0007/0005/3", sourceID, fChosenCH, fPacketType); end
    endtask

    task automatic test_payload;
        int a1;
        clear_q();
        send_pkt(mk(3'd2, 5'd3, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015), 0);
        a1 = last_acc;
        send_pkt(mk(3'd5, 5'd0, 16'h0022, 16'h0023, 16'h0024, 16'h0025, 16'h0026), 0);
        idle(3);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL payload_count: got %0d exp 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL payload_pkt[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        if (np_cyc.size() > 0) begin
            checks++; if (np_cyc[0] !== a1 + 1) begin errors++; $display("FAIL payload_latency: newpkt at %0d exp %0d", np_cyc[0], a1 + 1); end
            checks++; if (first_acc !== np_cyc[0] + 1) begin errors++; $display("FAIL payload_sop_on_newpkt: header accepted at %0d exp %0d", first_acc, np_cyc[0] + 1); end
        end
        checks++; if (first_stall !== 1) begin errors++; $display("FAIL payload_emit_stall: got %0d exp 1", first_stall); end
    endtask

    task automatic test_abort;
        int e0 = err_pulses;
        clear_q();
        send_word({3'd1, 5'd2, 8'h00}, 1'b1);
        send_word(16'h0031, 1'b0);
        send_word(16'h0032, 1'b0);
        send_pkt(mk(3'd4, 5'd0, 16'h0041, 16'h0042, 16'h0043, 16'h0044, 16'h0045), 0);
        idle(3);
        checks++; if (err_pulses !== e0 + 1) begin errors++; $display("FAIL abort_error: got %0d pulses exp %0d", err_pulses - e0, 1); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL abort_count: got %0d exp 1", got_q.size()); end
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL abort_pkt: got %h exp %h", got_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_timeout;
        pkt_t p = mk(3'd1, 5'd0, 16'h0051, 16'h0052, 16'h0053, 16'h0054, 16'h0055);
        int e0 = err_pulses;
        clear_q();
        send_word({p.typ, p.len, 8'h00}, 1'b1);
        send_word(p.src, 1'b0);
        send_word(p.dst, 1'b0);
        idle(63);
        send_word(p.hops, 1'b0);
        send_word(p.ch, 1'b0);
        send_word(p.ts, 1'b0);
        model_pkt(p);
        idle(3);
        checks++; if (err_pulses !== e0) begin errors++; $display("FAIL timeout63_error: got %0d pulses exp 0", err_pulses - e0); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL timeout63_count: got %0d exp 1", got_q.size()); end
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL timeout63_pkt: got %h exp %h", got_q[0], exp_q[0]); end
        end
        send_word({p.typ, p.len, 8'h00}, 1'b1);
        send_word(16'h0061, 1'b0);
        send_word(16'h0062, 1'b0);
        idle(64);
        send_word(16'h0063, 1'b0);
        send_word(16'h0064, 1'b0);
        send_word(16'h0065, 1'b0);
        idle(3);
        checks++; if (err_pulses !== e0 + 1) begin errors++; $display("FAIL timeout64_error: got %0d pulses exp 1", err_pulses - e0); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL timeout64_count: got %0d exp 1", got_q.size()); end
        checks++; if (pkt_count !== 8'(exp_pkt)) begin errors++; $display("FAIL timeout_pkt_count: got %0d exp %0d", pkt_count, exp_pkt); end
    endtask

    task automatic test_clear;
        clear_q();
        send_word(16'hdead, 1'b0);
        idle(7);
        checks++; if (channel_clear !== 1'b0) begin errors++; $display("FAIL clear_early: got %b exp 0 after 7 idle cycles", channel_clear); end
        idle(1);
        checks++; if (channel_clear !== 1'b1) begin errors++; $display("FAIL clear_set: got %b exp 1 after 8 idle cycles", channel_clear); end
        idle(5);
        checks++; if (channel_clear !== 1'b1) begin errors++; $display("FAIL clear_hold: got %b exp 1", channel_clear); end
        in_valid = 1'b1;
        in_data  = 16'h1234;
        idle(1);
        in_valid = 1'b0;
        checks++; if (channel_clear !== 1'b0) begin errors++; $display("FAIL clear_drop: got %b exp 0 after in_valid", channel_clear); end
        idle(2);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL clear_discard: got %0d pulses exp 0", got_q.size()); end
    endtask

    task automatic test_random;
        clear_q();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3, 0) == 0) send_word(16'($urandom), 1'b0);
            send_pkt(rnd_pkt($urandom_range(3, 0) != 0), 4);
        end
        idle(3);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_pkt[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (pkt_count !== 8'(exp_pkt) || drop_count !== 8'(exp_drop)) begin errors++; $display("FAIL random_counts: got %0d/%0d exp %0d/%0d", pkt_count, drop_count, exp_pkt, exp_drop); end
    endtask

    task automatic test_saturate;
        clear_q();
        repeat (300) send_pkt(rnd_pkt(1'b1), 0);
        idle(3);
        checks++; if (got_q.size() != 300) begin errors++; $display("FAIL sat_delivered: got %0d exp 300", got_q.size()); end
        checks++; if (pkt_count !== 8'(exp_pkt)) begin errors++; $display("FAIL sat_pkt_count: got %0d exp %0d", pkt_count, exp_pkt); end
        repeat (260) send_pkt(mk(3'd7, 5'd0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0), 0);
        idle(3);
        checks++; if (drop_count !== 8'(exp_drop)) begin errors++; $display("FAIL sat_drop_count: got %0d exp %0d", drop_count, exp_drop); end
    endtask

    task automatic test_reset_mid;
        int e0;
        clear_q();
        send_word({3'd2, 5'd1, 8'h00}, 1'b1);
        send_word(16'h0071, 1'b0);
        e0 = err_pulses;
        nrst = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b0 || pkt_count !== 8'd0 || drop_count !== 8'd0) begin errors++; $display("FAIL midreset_state: got %b/%0d/%0d exp 0/0/0", in_ready, pkt_count, drop_count); end
        checks++; if (sourceID !== 16'h0 || fPacketType !== 3'd0) begin errors++; $display("FAIL midreset_fields: got %h/%0d exp 0/0", sourceID, fPacketType); end
        @(posedge clk);
        #1 nrst = 1'b1;
        exp_pkt  = 0;
        exp_drop = 0;
        idle(2);
        send_word(16'h0072, 1'b0);
        send_pkt(mk(3'd6, 5'd2, 16'h0081, 16'h0082, 16'h0083, 16'h0084, 16'h0085), 2);
        idle(3);
        checks++; if (err_pulses !== e0) begin errors++; $display("FAIL midreset_error: got %0d pulses exp 0", err_pulses - e0); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL midreset_count: got %0d exp 1", got_q.size()); end
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL midreset_pkt: got %h exp %h", got_q[0], exp_q[0]); end
        end
        checks++; if (pkt_count !== 8'(exp_pkt)) begin errors++; $display("FAIL midreset_pkt_count: got %0d exp %0d", pkt_count, exp_pkt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_payload();
        test_abort();
        test_timeout();
        test_clear();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pkt_rx_parser.md
PKT_RX_PARSER -- requirements
Module: pkt_rx_parser

Interface
REQ-001 Parameter WORD_WIDTH, default 16, SHALL set the width of every data word and field.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the allowed inter-word gap inside a packet, in cycles.
REQ-003 Parameter CLEAR_CYCLES, default 8, SHALL set the idle cycles required before channel_clear asserts.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid / in_ready  input / output  1 / 1  word handshake; a word is accepted when both are 1 at a rising edge.
REQ-007 in_data  input  WORD_WIDTH  received word.
REQ-008 in_sop  input  1  marks in_data as a packet header.
REQ-009 myNodeID  input  WORD_WIDTH  own node ID, used for echo filtering.
REQ-010 newpkt  output  1  one-cycle pulse; field outputs are valid and stable.
REQ-011 fPacketType  output  3  header[15:13].
REQ-012 sourceID, destinationID, fHopsFromCH, fChosenCH, fTimeslot  output  WORD_WIDTH each  packet words 1..5.
REQ-013 channel_clear  output  1  medium idle indication.
REQ-014 rx_error  output  1  one-cycle pulse on abort.
REQ-015 pkt_count, drop_count  output  8 each  saturating counts of delivered and dropped packets.

Function
REQ-016 Packet format SHALL be: word0 header {type[15:13], payload_len[12:8], reserved[7:0]}; words 1..5 source, destination, hops, chosenCH, timeslot; then payload_len payload words.
REQ-017 The FSM SHALL have the states IDLE, FIELDS, SKIP and EMIT.
REQ-018 IDLE: in_ready SHALL be 1; an accepted word with in_sop=1 SHALL latch type and length, set word_cnt=1 and move to FIELDS; an accepted word with in_sop=0 SHALL be discarded silently.
REQ-019 FIELDS: in_ready SHALL be 1; accepted words 1..5 SHALL go into shadow registers, not into the outputs; after word 5, the FSM SHALL move to EMIT if payload_len=0 and to SKIP otherwise.
REQ-020 SKIP: in_ready SHALL be 1; payload words SHALL be accepted and discarded; after the payload_len-th payload word, the FSM SHALL move to EMIT.
REQ-021 EMIT: in_ready SHALL be 0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-022 EMIT, drop case: if shadow source equals myNodeID, or type is 3'b111, the packet SHALL be dropped; drop_count increments, outputs and newpkt are unchanged.
REQ-023 EMIT, delivery case: otherwise the shadow registers SHALL be copied to the outputs at the end of EMIT; newpkt is 1 for the next cycle only and pkt_count increments.
REQ-024 Latency: newpkt SHALL be high in the second cycle after the cycle in which the last word is accepted.
REQ-025 Field outputs SHALL hold their values until the next delivered packet.
REQ-026 An accepted word with in_sop=1 in FIELDS or SKIP SHALL abort the current packet, pulse rx_error, and restart as a header (word_cnt=1, state FIELDS).
REQ-027 Timeout: a gap counter SHALL clear on every accepted word in FIELDS or SKIP and increment on every other cycle in those states.
REQ-028 When the gap counter reaches TIMEOUT, the block SHALL pulse rx_error, discard the packet and go to IDLE.
REQ-029 pkt_count and drop_count SHALL saturate at 255 and not wrap.
REQ-030 channel_clear SHALL be registered; an idle counter SHALL increment in IDLE when in_valid=0, saturating at CLEAR_CYCLES, and clear otherwise.
REQ-031 channel_clear SHALL be 1 exactly when the idle counter equals CLEAR_CYCLES.
REQ-032 The block SHALL not decode packet types; type is passed through unchanged except for the 3'b111 drop.

Reset
REQ-033 With nrst=0, the FSM SHALL be IDLE and all counters, shadow registers and outputs SHALL be 0, with in_ready=0.
REQ-034 in_ready SHALL go to 1 on the first edge after nrst deasserts.
REQ-035 Reset mid-packet SHALL discard the packet without an rx_error pulse.

Verification
REQ-036 Header 16'h6000 (type 3, len 0), words 0x0007, 0x0002, 0x0001, 0x0005, 0x0003, myNodeID=2 -> newpkt pulse 2 cycles after the last word; fPacketType=3, sourceID=7, fChosenCH=5; pkt_count=1.
REQ-037 Same packet with sourceID=2=myNodeID -> no newpkt, drop_count=1, outputs unchanged.
REQ-038 Header with len=3 -> 3 payload words accepted, then newpkt; a new sop in the cycle newpkt is high is accepted.
REQ-039 in_sop=1 on word 3 -> rx_error pulse; that word is parsed as a new header and the following packet is delivered correctly.
REQ-040 Stall of 64 cycles after word 2 -> rx_error pulse and return to IDLE; 63 cycles -> no error.
REQ-041 Idle with in_valid=0 -> channel_clear=1 after 8 cycles and 0 the cycle after in_valid=1; 300 packets -> pkt_count=255.
